// File: rtl/zigzag_serializer.sv
// zigzag_serializer: buffers one 8x8 block and streams it in JPEG zigzag order; optional ZIGZAG_EOB_SKIP_EN trims trailing zeros
module zigzag_serializer #(
  parameter int DATA_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [64*DATA_W-1:0]   in_block,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [5:0]             out_idx,
  output logic                   out_last
`ifdef ZIGZAG_EOB_SKIP_EN
  ,
  output logic                   eob_skip
`endif
);
  localparam logic [5:0] ZZ [64] = '{
    0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [5:0] idx, idx_nx, last_idx;
  logic [DATA_W-1:0] mem [64];
  logic last, accept, beat;
`ifdef ZIGZAG_EOB_SKIP_EN
  logic [5:0] eob, eob_nx;
  // Highest zigzag position holding a nonzero coefficient in the offered block
  always_comb begin
    eob_nx = '0;
    for (int k = 0; k < 64; k++)
      if (in_block[int'(ZZ[k])*DATA_W +: DATA_W] != '0) eob_nx = 6'(k);
  end
  // Trailing-zero marker on the terminating beat
  always_comb eob_skip = last && eob != 6'd63;
  // End-of-block position of the block currently being sent
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) eob <= 6'd63;
    else if (accept) eob <= eob_nx;
  assign last_idx = eob;
`else
  assign last_idx = 6'd63;
`endif
  // Coefficient buffer kept in natural row-major order, written only on accept
  always_ff @(posedge clock)
    if (accept)
      for (int i = 0; i < 64; i++) mem[i] <= in_block[i*DATA_W +: DATA_W];
  // Handshakes, outputs and next state; a final-beat accept can reload in the same cycle
  always_comb begin
    last      = state == SEND && idx == last_idx;
    out_valid = state == SEND;
    in_ready  = state == IDLE || (out_ready && last);
    accept    = in_valid && in_ready;
    beat      = out_valid && out_ready;
    out_last  = last;
    out_idx   = idx;
    out_data  = out_valid ? mem[ZZ[idx]] : '0;
    state_nx  = accept ? SEND : (beat && last) ? IDLE : state;
    idx_nx    = (accept || (beat && last)) ? 6'd0 : beat ? idx + 6'd1 : idx;
  end
  // State and scan position registers
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
endmodule
